// File: rtl/board_tile_scanner.sv
// Walks the 8x8 minesweeper board and issues one go/busy tile-draw request per cell,
// optionally skipping cells whose colour has not changed since they were last drawn.
module board_tile_scanner #(
  parameter int X_ORIGIN   = 4,
  parameter int Y_ORIGIN   = 4,
  parameter int TILE_W     = 19,
  parameter int TILE_H     = 14,
  parameter bit DIRTY_ONLY = 1'b1,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scan_start,
  input  logic [63:0] mine_map,
  input  logic [63:0] flag_map,
  input  logic [63:0] step_map,
  input  logic [5:0]  cursor,
  input  logic        tile_busy,
  output logic        tile_go,
  output logic [7:0]  tile_x,
  output logic [6:0]  tile_y,
  output logic [2:0]  tile_color,
  output logic        scan_busy,
  output logic        scan_done,
  output logic [6:0]  cells_drawn,
  output logic        timeout_err
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, SNAP, EVAL, REQ, WAIT, NEXT, DONE} state_t;

  state_t      state;
  logic [63:0] mine_q, flag_q, step_q;
  logic [5:0]  cursor_q;
  logic [5:0]  idx;
  logic [WD_W-1:0] wdog;
  logic [63:0] valid;
  logic [2:0]  mem_color [64];

  logic [2:0]  cell_color;
  logic [7:0]  cell_x;
  logic [6:0]  cell_y;
  logic        skip;

  always_comb begin
    cell_color = 3'b001;
    if (step_q[idx] && mine_q[idx])  cell_color = 3'b100;
    else if (step_q[idx])            cell_color = 3'b111;
    else if (idx == cursor_q)        cell_color = 3'b010;
    else if (flag_q[idx])            cell_color = 3'b110;
    cell_x = 8'(X_ORIGIN + int'(idx[2:0]) * TILE_W);
    cell_y = 7'(Y_ORIGIN + int'(idx[5:3]) * TILE_H);
    skip   = DIRTY_ONLY && valid[idx] && (mem_color[idx] == cell_color);
  end

  // Colour memory needs no reset; the valid vector alone decides whether an entry is trusted.
  always_ff @(posedge clk) begin
    if (state == WAIT && !tile_busy)
      mem_color[idx] <= tile_color;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      mine_q      <= '0;
      flag_q      <= '0;
      step_q      <= '0;
      cursor_q    <= '0;
      idx         <= '0;
      wdog        <= '0;
      valid       <= '0;
      tile_go     <= 1'b0;
      tile_x      <= '0;
      tile_y      <= '0;
      tile_color  <= '0;
      scan_busy   <= 1'b0;
      scan_done   <= 1'b0;
      cells_drawn <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_start) begin
            scan_busy <= 1'b1;
            state     <= SNAP;
          end
        end
        SNAP: begin
          mine_q      <= mine_map;
          flag_q      <= flag_map;
          step_q      <= step_map;
          cursor_q    <= cursor;
          idx         <= '0;
          cells_drawn <= '0;
          timeout_err <= 1'b0;
          state       <= EVAL;
        end
        EVAL: begin
          if (skip) begin
            state <= NEXT;
          end else begin
            tile_x     <= cell_x;
            tile_y     <= cell_y;
            tile_color <= cell_color;
            tile_go    <= 1'b1;
            wdog       <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          // A busy already high on entry is taken as acceptance of this request.
          if (tile_busy) begin
            tile_go     <= 1'b0;
            cells_drawn <= cells_drawn + 7'd1;
            state       <= WAIT;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            tile_go     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= NEXT;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        WAIT: begin
          if (!tile_busy) begin
            valid[idx] <= 1'b1;
            state      <= NEXT;
          end
        end
        NEXT: begin
          if (idx == 6'd63) begin
            scan_done <= 1'b1;
            scan_busy <= 1'b0;
            state     <= DONE;
          end else begin
            idx   <= idx + 6'd1;
            state <= EVAL;
          end
        end
        DONE: begin
          scan_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_tile_scanner.sv
// Self-checking bench for board_tile_scanner: a drawer model acks requests and a
// scoreboard queue of expected tiles is compared against every tile_go pulse.
module tb_board_tile_scanner;

  logic        clk = 1'b0;
  logic        resetn;
  logic        scan_start;
  logic [63:0] mine_map, flag_map, step_map;
  logic [5:0]  cursor;
  logic        tile_busy = 1'b0;
  logic        tile_go;
  logic [7:0]  tile_x;
  logic [6:0]  tile_y;
  logic [2:0]  tile_color;
  logic        scan_busy, scan_done;
  logic [6:0]  cells_drawn;
  logic        timeout_err;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
  } req_t;

  req_t exp_q[$];
  req_t obs_q[$];
  req_t e_req, o_req;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int go_count = 0, done_count = 0, go_width = 0, last_go_width = 0;
  int go_base = 0, done_base = 0, start_cyc = 0, done_cyc = 0;
  int d_phase = 0, d_count = 0;
  bit drawer_en = 1'b1;
  logic prev_go = 1'b0;
  logic       model_valid [64];
  logic [2:0] model_color [64];

  board_tile_scanner dut (
    .clk(clk), .resetn(resetn), .scan_start(scan_start),
    .mine_map(mine_map), .flag_map(flag_map), .step_map(step_map),
    .cursor(cursor), .tile_busy(tile_busy), .tile_go(tile_go),
    .tile_x(tile_x), .tile_y(tile_y), .tile_color(tile_color),
    .scan_busy(scan_busy), .scan_done(scan_done),
    .cells_drawn(cells_drawn), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [2:0] modelColor(input int i);
    if (step_map[i] && mine_map[i]) return 3'b100;
    if (step_map[i])                return 3'b111;
    if (i == int'(cursor))          return 3'b010;
    if (flag_map[i])                return 3'b110;
    return 3'b001;
  endfunction

  // Drawer model and monitor: acks two cycles after go rises, holds busy for 16 cycles.
  always @(negedge clk) begin
    if (!resetn) begin
      d_phase   = 0;
      tile_busy = 1'b0;
      prev_go   = 1'b0;
      go_width  = 0;
    end else begin
      if (scan_done) done_count++;
      case (d_phase)
        1: begin
          d_count--;
          if (d_count == 0) begin
            tile_busy = 1'b1;
            d_count   = 16;
            d_phase   = 2;
          end
        end
        2: begin
          d_count--;
          if (d_count == 0) begin
            tile_busy = 1'b0;
            d_phase   = 0;
          end
        end
        default: ;
      endcase
      if (tile_go) go_width++;
      else if (prev_go) begin
        last_go_width = go_width;
        go_width = 0;
      end
      if (tile_go && !prev_go) begin
        go_count++;
        o_req.x = tile_x;
        o_req.y = tile_y;
        o_req.color = tile_color;
        obs_q.push_back(o_req);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_go", 32'd1, 32'd0);
        end else begin
          e_req = exp_q.pop_front();
          checkOutput("req_x", 32'(tile_x), 32'(e_req.x));
          checkOutput("req_y", 32'(tile_y), 32'(e_req.y));
          checkOutput("req_color", 32'(tile_color), 32'(e_req.color));
        end
        if (drawer_en) begin
          d_phase = 1;
          d_count = 2;
        end
      end
      prev_go = tile_go;
    end
  end

  task automatic clearModel();
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      model_valid[i] = 1'b0;
      model_color[i] = 3'b000;
    end
  endtask

  // Pushes the tiles the snapshot should produce, then pulses scan_start for one cycle.
  task automatic applyStimulus();
    req_t r;
    logic [2:0] c;
    obs_q.delete();
    for (int i = 0; i < 64; i++) begin
      c = modelColor(i);
      if (!(model_valid[i] && model_color[i] == c)) begin
        r.x = 8'(4 + (i % 8) * 19);
        r.y = 7'(4 + (i / 8) * 14);
        r.color = c;
        exp_q.push_back(r);
        if (drawer_en) begin
          model_valid[i] = 1'b1;
          model_color[i] = c;
        end
      end
    end
    @(negedge clk);
    go_base    = go_count;
    done_base  = done_count;
    scan_start = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!scan_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scan_done_seen", 32'(scan_done), 32'd1);
    done_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic checkScan(input string tag, input int exp_cells, input int exp_gos);
    checkOutput({tag, "_cells"}, 32'(cells_drawn), 32'(exp_cells));
    checkOutput({tag, "_gos"}, 32'(go_count - go_base), 32'(exp_gos));
    checkOutput({tag, "_dones"}, 32'(done_count - done_base), 32'd1);
    checkOutput({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkObs(input string tag, input int k, input int x, input int y, input int c);
    checkOutput({tag, "_x"}, 32'(obs_q[k].x), 32'(x));
    checkOutput({tag, "_y"}, 32'(obs_q[k].y), 32'(y));
    checkOutput({tag, "_color"}, 32'(obs_q[k].color), 32'(c));
  endtask

  task automatic pulseReset();
    @(negedge clk);
    resetn = 1'b0;
    clearModel();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int n;
    resetn     = 1'b0;
    scan_start = 1'b0;
    mine_map   = '0;
    flag_map   = '0;
    step_map   = '0;
    cursor     = '0;
    clearModel();
    repeat (3) @(negedge clk);
    checkOutput("rst_go", 32'(tile_go), 32'd0);
    checkOutput("rst_busy", 32'(scan_busy), 32'd0);
    checkOutput("rst_done", 32'(scan_done), 32'd0);
    checkOutput("rst_cells", 32'(cells_drawn), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
    checkOutput("rst_xyc", {14'd0, tile_x, tile_y, tile_color}, 32'd0);
    resetn = 1'b1;

    // Full first scan: every cell drawn in index order.
    applyStimulus();
    checkOutput("scan1_busy", 32'(scan_busy), 32'd1);
    waitDone(5000);
    checkScan("scan1", 64, 64);
    checkOutput("scan1_obs", 32'(obs_q.size()), 32'd64);
    if (obs_q.size() == 64) begin
      checkObs("scan1_first", 0, 4, 4, 3'b010);
      checkObs("scan1_second", 1, 23, 4, 3'b001);
      checkObs("scan1_last", 63, 137, 102, 3'b001);
    end

    // Unchanged board: nothing dirty, minimum scan length.
    applyStimulus();
    waitDone(500);
    checkScan("scan2", 0, 0);
    checkOutput("scan2_len", 32'(done_cyc - start_cyc), 32'd130);

    // Two dirty cells only.
    step_map[9]  = 1'b1;
    mine_map[9]  = 1'b1;
    flag_map[63] = 1'b1;
    applyStimulus();
    waitDone(2000);
    checkScan("scan3", 2, 2);
    checkOutput("scan3_obs", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      checkObs("scan3_a", 0, 23, 18, 3'b100);
      checkObs("scan3_b", 1, 137, 102, 3'b110);
    end

    // Reset invalidates memory; then reset again while requesting idx 20.
    pulseReset();
    applyStimulus();
    n = 0;
    while (go_count < go_base + 21 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("go_before_reset", 32'(tile_go), 32'd1);
    #1 resetn = 1'b0;
    #1;
    checkOutput("go_async_drop", 32'(tile_go), 32'd0);
    checkOutput("busy_async_drop", 32'(scan_busy), 32'd0);
    clearModel();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("idle_go", 32'(tile_go), 32'd0);
    checkOutput("idle_busy", 32'(scan_busy), 32'd0);
    applyStimulus();
    waitDone(5000);
    checkScan("redraw", 64, 64);

    // Drawer never answers: every cell times out.
    pulseReset();
    drawer_en = 1'b0;
    applyStimulus();
    waitDone(70000);
    checkScan("timeout", 0, 64);
    checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);
    checkOutput("timeout_go_width", 32'(last_go_width), 32'd1023);
    drawer_en = 1'b1;

    // New snapshot, everything undrawn; scan_start and map changes mid-scan are ignored.
    mine_map = 64'h0123_4567_89ab_cdef;
    step_map = 64'h00ff_0000_f0f0_1234;
    flag_map = 64'h8000_0001_0f00_0300;
    cursor   = 6'd27;
    applyStimulus();
    @(negedge clk);
    checkOutput("timeout_err_clr", 32'(timeout_err), 32'd0);
    n = 0;
    while (go_count < go_base + 11 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    scan_start = 1'b1;
    mine_map   = ~mine_map;
    step_map   = ~step_map;
    @(negedge clk);
    scan_start = 1'b0;
    waitDone(5000);
    checkScan("midstart", 64, 64);
    n = go_count;
    repeat (50) @(negedge clk);
    checkOutput("no_restart_busy", 32'(scan_busy), 32'd0);
    checkOutput("no_restart_gos", 32'(go_count), 32'(n));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
